// File: rtl/mux_gate_pkg.sv
// Shared opcode encoding for the mux-built gate pipeline.
package mux_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

endpackage

// File: rtl/mux2_cell.sv
// Single-bit 2:1 mux; the only primitive the gate unit is built from.
module mux2_cell (
  input  logic s,
  input  logic d1,
  input  logic d0,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_gate_pipe.sv
// Two-stage valid/ready bitwise gate unit built from per-bit 2:1 muxes, with a saturating result count.
// Optional y_par output (even parity of y) when MUX_GATE_PIPE_PARITY_EN is defined.
module mux_gate_pipe
  import mux_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] op_count
`ifdef MUX_GATE_PIPE_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  gate_op_e         s1_op;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] mux_y;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Operand a steers every mux; the opcode only chooses what the two data legs carry.
  always_comb begin
    d1 = '0;
    d0 = '0;
    case (s1_op)
      OP_AND:  begin d1 = s1_b;  d0 = '0;     end
      OP_OR:   begin d1 = '1;    d0 = s1_b;  end
      OP_XOR:  begin d1 = ~s1_b; d0 = s1_b;  end
      OP_NAND: begin d1 = ~s1_b; d0 = '1;    end
      OP_NOR:  begin d1 = '0;    d0 = ~s1_b; end
      OP_XNOR: begin d1 = s1_b;  d0 = ~s1_b; end
      OP_NOT:  begin d1 = '0;    d0 = '1;    end
      OP_BUF:  begin d1 = '1;    d0 = '0;    end
      default: begin d1 = '0;    d0 = '0;    end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2_cell u_cell (
      .s  (s1_a[i]),
      .d1 (d1[i]),
      .d0 (d0[i]),
      .y  (mux_y[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
      s2_valid <= 1'b0;
      y        <= '0;
      op_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= a;
          s1_b  <= b;
          s1_op <= gate_op_e'(op);
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) y <= mux_y;
      end
      if (out_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

`ifdef MUX_GATE_PIPE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      y_par <= ^mux_y;
    end
  end
`endif

endmodule
